video_line_prefetch: RTL and testbench

//  Scanline prefetcher between the VGA timing generator and the pixel output path.

---
 rtl/video_line_prefetch.sv | 176 +++++++++++++++++
 tb/tb_video_line_prefetch.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_prefetch.sv
// Scanline prefetcher: fetches the next framebuffer line from VRAM into a
// two-bank line buffer while the current line is shown, then serves pixels by position.
module video_line_prefetch #(
  parameter int MAX_WIDTH = 720,
  parameter int POS_WIDTH = 11
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [31:0]          i_base,
  input  logic [15:0]          i_pitch,
  input  logic [POS_WIDTH-1:0] i_width,
  input  logic [POS_WIDTH-1:0] i_height,
  input  logic                 i_video_hblank,
  input  logic                 i_video_vblank,
  input  logic [POS_WIDTH-1:0] i_video_pos_x,
  input  logic [POS_WIDTH-1:0] i_video_pos_y,
  output logic [31:0]          o_video_rdata,
  output logic                 o_bus_request,
  output logic                 o_bus_rw,
  output logic [31:0]          o_bus_address,
  input  logic [31:0]          i_bus_rdata,
  input  logic                 i_bus_ready,
  output logic                 o_underrun,
  input  logic                 i_underrun_clear
);

  // state | meaning
  // IDLE  | no fetch in progress, waiting for a line trigger
  // REQ   | word request outstanding, held until i_bus_ready
  // GAP   | one low cycle between words; advance, restart or finish
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int BUF_AW = $clog2(2 * MAX_WIDTH);
  localparam logic [POS_WIDTH-1:0] MAX_W     = POS_WIDTH'(MAX_WIDTH);
  localparam logic [BUF_AW-1:0]    BANK1_OFS = BUF_AW'(MAX_WIDTH);

  logic                 hblank_q, vblank_q;
  logic [15:0]          pitch_q;
  logic [POS_WIDTH-1:0] width_q, height_q;
  logic [31:0]          line_addr_q, line_addr_d;
  logic [31:0]          cur_addr_q, cur_addr_d;
  logic [POS_WIDTH-1:0] x_q, x_d;
  logic                 bank_q, bank_d;
  logic                 pend_q, pend_d;
  logic                 pend_bank_q, pend_bank_d;
  logic [1:0]           state_q, state_d;
  logic                 underrun_q, underrun_d;
  logic                 rd_vld_q, rd_vld_d;
  logic [31:0]          rd_q;
  logic [31:0]          buf_q [2*MAX_WIDTH];

  logic                 trig_t0, trig_t1, accept, busy, new_bank, wr_en;
  logic [POS_WIDTH-1:0] cfg_width, x_inc, rd_x;
  logic [POS_WIDTH:0]   next_y;
  logic [31:0]          new_addr;
  logic [BUF_AW-1:0]    wr_idx, rd_idx;

  assign cfg_width = (i_width > MAX_W) ? MAX_W : i_width;
  assign next_y    = {1'b0, i_video_pos_y} + (POS_WIDTH+1)'(1);
  assign trig_t0   = i_video_vblank & ~vblank_q;
  assign trig_t1   = ~i_video_hblank & hblank_q & ~i_video_vblank & (next_y < {1'b0, height_q});
  // T0 latches the new width in the same cycle, so it is judged on the incoming value
  assign accept    = i_enable & (trig_t0 ? (cfg_width != '0) : ((width_q != '0) & trig_t1));
  assign new_addr  = trig_t0 ? i_base : line_addr_q + {16'b0, pitch_q};
  assign new_bank  = trig_t0 ? 1'b0 : ~i_video_pos_y[0];
  assign busy      = (state_q != ST_IDLE);
  assign x_inc     = x_q + POS_WIDTH'(1);
  assign wr_en     = (state_q == ST_REQ) & i_bus_ready;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    bank_d      = bank_q;
    cur_addr_d  = cur_addr_q;
    line_addr_d = line_addr_q;
    pend_d      = pend_q;
    pend_bank_d = pend_bank_q;
    underrun_d  = underrun_q & ~i_underrun_clear;
    if (accept) begin
      line_addr_d = new_addr;
      if (busy) begin
        underrun_d  = 1'b1;
        pend_d      = 1'b1;
        pend_bank_d = new_bank;
      end
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cur_addr_d = new_addr;
          bank_d     = new_bank;
          x_d        = '0;
          state_d    = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_bus_ready) state_d = ST_GAP;
      end
      ST_GAP: begin
        if (!i_enable) begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end else if (pend_q || accept) begin
          // a late trigger abandons the rest of the old line
          cur_addr_d = accept ? new_addr : line_addr_q;
          bank_d     = accept ? new_bank : pend_bank_q;
          x_d        = '0;
          pend_d     = 1'b0;
          state_d    = ST_REQ;
        end else begin
          x_d     = x_inc;
          state_d = (x_inc >= width_q) ? ST_IDLE : ST_REQ;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rd_x     = (i_video_pos_x < width_q) ? i_video_pos_x : '0;
  assign rd_idx   = (i_video_pos_y[0] ? BANK1_OFS : '0) + BUF_AW'(rd_x);
  assign wr_idx   = (bank_q ? BANK1_OFS : '0) + BUF_AW'(x_q);
  assign rd_vld_d = i_enable & ~i_video_vblank & ~i_video_hblank & (i_video_pos_x < width_q);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      hblank_q    <= 1'b0;
      vblank_q    <= 1'b0;
      pitch_q     <= '0;
      width_q     <= '0;
      height_q    <= '0;
      line_addr_q <= '0;
      cur_addr_q  <= '0;
      x_q         <= '0;
      bank_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_bank_q <= 1'b0;
      state_q     <= ST_IDLE;
      underrun_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
    end else begin
      hblank_q    <= i_video_hblank;
      vblank_q    <= i_video_vblank;
      if (trig_t0) begin
        pitch_q  <= i_pitch;
        width_q  <= cfg_width;
        height_q <= i_height;
      end
      line_addr_q <= line_addr_d;
      cur_addr_q  <= cur_addr_d;
      x_q         <= x_d;
      bank_q      <= bank_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      state_q     <= state_d;
      underrun_q  <= underrun_d;
      rd_vld_q    <= rd_vld_d;
    end
  end

  // Line buffer has no reset so it maps onto block RAM; the valid flag masks stale data.
  always_ff @(posedge i_clock) begin
    if (wr_en) buf_q[wr_idx] <= i_bus_rdata;
    rd_q <= buf_q[rd_idx];
  end

  assign o_video_rdata = rd_vld_q ? rd_q : '0;
  assign o_bus_request = (state_q == ST_REQ);
  assign o_bus_rw      = 1'b0;
  assign o_bus_address = (state_q == ST_REQ) ?
                         cur_addr_q + {{(32-POS_WIDTH-2){1'b0}}, x_q, 2'b00} : '0;
  assign o_underrun    = underrun_q;

endmodule

// File: tb/tb_video_line_prefetch.sv
// Directed bench for video_line_prefetch: VRAM model returns addr>>2 as data,
// video timing is generated per frame and every displayed pixel is compared.
module tb_video_line_prefetch;

  logic        clk = 1'b0;
  logic        i_reset, i_enable;
  logic [31:0] i_base;
  logic [15:0] i_pitch;
  logic [10:0] i_width, i_height;
  logic        i_video_hblank, i_video_vblank;
  logic [10:0] i_video_pos_x, i_video_pos_y;
  logic [31:0] o_video_rdata;
  logic        o_bus_request, o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;
  logic        o_underrun;
  logic        i_underrun_clear;

  int checks = 0;
  int errors = 0;

  int          lat = 0, wcnt = 0, nfetch = 0, viol = 0, gap1 = 0, low_run = 0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  always #5 clk = ~clk;

  video_line_prefetch dut (
    .i_clock(clk), .i_reset(i_reset), .i_enable(i_enable),
    .i_base(i_base), .i_pitch(i_pitch), .i_width(i_width), .i_height(i_height),
    .i_video_hblank(i_video_hblank), .i_video_vblank(i_video_vblank),
    .i_video_pos_x(i_video_pos_x), .i_video_pos_y(i_video_pos_y),
    .o_video_rdata(o_video_rdata),
    .o_bus_request(o_bus_request), .o_bus_rw(o_bus_rw), .o_bus_address(o_bus_address),
    .i_bus_rdata(i_bus_rdata), .i_bus_ready(i_bus_ready),
    .o_underrun(o_underrun), .i_underrun_clear(i_underrun_clear)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // VRAM with mem[i]=i, optional wait states, plus handshake monitoring
  always @(negedge clk) begin
    if (i_reset) begin
      if (prev_req && !i_bus_ready && (!o_bus_request || o_bus_address !== prev_addr)) viol++;
      if (i_bus_ready && o_bus_request) viol++;
      if (o_bus_request && !prev_req && low_run == 1) gap1++;
    end
    low_run   = o_bus_request ? 0 : low_run + 1;
    prev_req  = o_bus_request;
    prev_addr = o_bus_address;
    if (i_bus_ready) i_bus_ready = 1'b0;
    else if (o_bus_request) begin
      if (wcnt >= lat) begin
        i_bus_ready = 1'b1;
        i_bus_rdata = o_bus_address >> 2;
        nfetch++;
        wcnt = 0;
      end else wcnt++;
    end else wcnt = 0;
  end

  task automatic clr_mon();
    nfetch = 0; viol = 0; gap1 = 0;
  endtask

  task automatic run_frame(input logic [31:0] base, input logic [15:0] pitch,
                           input int width, input int height, input int act,
                           input int hb, input int vb, input logic en);
    int          wl;
    logic [31:0] exp_px, addr;
    logic        chk;
    wl     = (width > 720) ? 720 : width;
    chk    = 1'b0;
    exp_px = '0;
    i_base = base; i_pitch = pitch; i_width = 11'(width); i_height = 11'(height);
    i_enable = en;
    for (int c = 0; c < vb; c++) begin
      @(negedge clk);
      if (chk) check_eq("pix", o_video_rdata, exp_px);
      chk = 1'b0;
      i_video_vblank = 1'b1; i_video_hblank = 1'b1;
      i_video_pos_x = '0; i_video_pos_y = '0;
    end
    for (int y = 0; y < height; y++) begin
      for (int c = 0; c < hb + act; c++) begin
        @(negedge clk);
        if (chk) check_eq("pix", o_video_rdata, exp_px);
        i_video_vblank = 1'b0;
        i_video_hblank = (c < hb);
        i_video_pos_y  = 11'(y);
        i_video_pos_x  = (c < hb) ? 11'd0 : 11'(c - hb);
        chk    = (c >= hb);
        addr   = base + 32'(y) * {16'b0, pitch} + 32'(4 * (c - hb));
        exp_px = (en && c >= hb && (c - hb) < wl) ? (addr >> 2) : 32'd0;
      end
    end
    @(negedge clk);
    if (chk) check_eq("pix", o_video_rdata, exp_px);
    i_video_hblank = 1'b1;
    i_video_pos_x  = '0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    int nf0;
    i_reset = 1'b0; i_enable = 1'b0; i_base = '0; i_pitch = '0; i_width = '0; i_height = '0;
    i_video_hblank = 1'b1; i_video_vblank = 1'b0; i_video_pos_x = '0; i_video_pos_y = '0;
    i_bus_rdata = '0; i_bus_ready = 1'b0; i_underrun_clear = 1'b0;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    check_eq("rst_rdata", o_video_rdata, 0);
    check_eq("rst_req", o_bus_request, 0);
    check_eq("rst_rw", o_bus_rw, 0);
    check_eq("rst_addr", o_bus_address, 0);
    check_eq("rst_urun", o_underrun, 0);

    // basic frame
    clr_mon(); lat = 0;
    run_frame(32'h0, 16'd32, 8, 4, 12, 10, 30, 1'b1);
    check_eq("a_nfetch", nfetch, 32);
    check_eq("a_viol", viol, 0);
    check_eq("a_urun", o_underrun, 0);

    // base near top of address space: line 1 wraps to 0x10
    clr_mon();
    run_frame(32'hFFFF_FFE0, 16'd48, 6, 3, 8, 10, 20, 1'b1);
    check_eq("b_nfetch", nfetch, 18);
    check_eq("b_urun", o_underrun, 0);

    // three wait states per word
    clr_mon(); lat = 3;
    run_frame(32'h100, 16'd64, 5, 3, 8, 24, 40, 1'b1);
    check_eq("c_nfetch", nfetch, 15);
    check_eq("c_viol", viol, 0);
    check_eq("c_gap1", gap1, 12);
    check_eq("c_urun", o_underrun, 0);

    // oversize width is clamped to 720
    clr_mon(); lat = 0;
    run_frame(32'h0, 16'd2880, 900, 2, 730, 760, 1500, 1'b1);
    check_eq("d_nfetch", nfetch, 1440);
    check_eq("d_viol", viol, 0);
    check_eq("d_urun", o_underrun, 0);

    // disabled frame, then re-enabled
    clr_mon();
    run_frame(32'h0, 16'd32, 8, 4, 12, 10, 30, 1'b0);
    check_eq("e_nfetch", nfetch, 0);
    check_eq("e_req", o_bus_request, 0);
    clr_mon();
    run_frame(32'h0, 16'd32, 8, 4, 12, 10, 30, 1'b1);
    check_eq("e2_nfetch", nfetch, 32);

    // underrun: slow bus, line 0 still fetching at the first hblank fall
    lat = 20;
    i_base = 32'h40; i_pitch = 16'd32; i_width = 11'd8; i_height = 11'd4; i_enable = 1'b1;
    @(negedge clk);
    i_video_vblank = 1'b1; i_video_hblank = 1'b1; i_video_pos_x = '0; i_video_pos_y = '0;
    repeat (5) @(negedge clk);
    i_video_vblank = 1'b0;
    repeat (2) @(negedge clk);
    i_video_hblank = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("f_urun_set", o_underrun, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (!o_bus_request) found = 1'b1;
    end
    check_eq("f_hs_done", found, 1);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_bus_request) found = 1'b1;
    end
    check_eq("f_restart_req", found, 1);
    check_eq("f_restart_addr", o_bus_address, 32'h60);
    check_eq("f_urun_hold", o_underrun, 1);
    i_video_hblank = 1'b1;
    @(negedge clk);
    i_video_hblank = 1'b0; i_video_pos_y = 11'd1; i_underrun_clear = 1'b1;
    @(negedge clk);
    i_underrun_clear = 1'b0;
    check_eq("f_set_wins", o_underrun, 1);
    i_underrun_clear = 1'b1;
    @(negedge clk);
    i_underrun_clear = 1'b0;
    check_eq("f_urun_clr", o_underrun, 0);

    // async reset in the middle of a request
    found = o_bus_request;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (o_bus_request) found = 1'b1;
    end
    check_eq("g_req_seen", found, 1);
    #2 i_reset = 1'b0;
    #1;
    check_eq("g_async_req", o_bus_request, 0);
    check_eq("g_async_addr", o_bus_address, 0);
    repeat (2) @(negedge clk);
    i_reset = 1'b1;
    lat = 0;
    @(negedge clk);
    check_eq("g_urun", o_underrun, 0);
    nf0 = nfetch;
    for (int k = 0; k < 2; k++) begin
      i_video_hblank = 1'b1;
      repeat (2) @(negedge clk);
      i_video_hblank = 1'b0; i_video_pos_y = 11'(k);
      repeat (3) @(negedge clk);
    end
    check_eq("g_idle_fetch", nfetch - nf0, 0);
    check_eq("g_idle_req", o_bus_request, 0);
    i_video_hblank = 1'b1;
    clr_mon();
    run_frame(32'h200, 16'd32, 8, 4, 12, 10, 30, 1'b1);
    check_eq("g_nfetch", nfetch, 32);
    check_eq("g_viol", viol, 0);
    check_eq("end_rw", o_bus_rw, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
